lcd_cmd_sequencer: RTL and testbench

- Sits directly downstream of the LSU and consumes the 32-bit LCD I/O register value the LSU drives on o_io_lcd, plus a write strobe when a store hits the LCD address.
- Turns each register write into one correctly timed HD44780 bus transaction: RS/RW setup, EN pulse, hold, then execution wait.
- Drives the LCD pins, reports busy, and captures read data.
- Holds a one-deep pending command, so the CPU can issue back-to-back stores without software delay loops.

---
 rtl/lcd_pkg.sv | 51 +++++
 rtl/lcd_cmd_sequencer.sv | 147 ++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 command sequencer:
// FSM states, register bit positions, command struct and the power-up init ROM.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } lcd_state_t;

  localparam int LCD_ON_BIT   = 31;
  localparam int LCD_BLON_BIT = 30;
  localparam int LCD_RS_BIT   = 9;
  localparam int LCD_RW_BIT   = 8;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } lcd_cmd_t;

  // Function set 8-bit/2-line, display on, clear, entry mode increment.
  localparam int         INIT_LEN   = 4;
  localparam logic [7:0] INIT_CMD_0 = 8'h38;
  localparam logic [7:0] INIT_CMD_1 = 8'h0C;
  localparam logic [7:0] INIT_CMD_2 = 8'h01;
  localparam logic [7:0] INIT_CMD_3 = 8'h06;

  function automatic lcd_cmd_t init_cmd(input logic [1:0] idx);
    lcd_cmd_t c;
    c.rs = 1'b0;
    c.rw = 1'b0;
    case (idx)
      2'd0:    c.data = INIT_CMD_0;
      2'd1:    c.data = INIT_CMD_1;
      2'd2:    c.data = INIT_CMD_2;
      default: c.data = INIT_CMD_3;
    endcase
    return c;
  endfunction

  // Clear display and return home need the long execution time.
  function automatic logic is_long_cmd(input lcd_cmd_t c);
    return !c.rs && !c.rw && (c.data inside {8'h01, 8'h02, 8'h03});
  endfunction

endpackage

// File: rtl/lcd_cmd_sequencer.sv
// Turns LCD register stores into timed HD44780 bus transactions with a one-deep pending slot.
// Optional power-up auto-init sequence is enabled by defining LCD_AUTO_INIT_EN.
//
// state | meaning
// PWRUP | power-on delay before auto-init (LCD_AUTO_INIT_EN only)
// INIT  | load next init ROM command (LCD_AUTO_INIT_EN only)
// IDLE  | waiting for a pending command
// SETUP | rs/rw/dq stable before EN rises
// PULSE | EN high
// HOLD  | EN low, bus held
// WAIT  | execution wait, bus released
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_EN        = 12,
  parameter int unsigned T_HOLD      = 1,
  parameter int unsigned T_EXEC      = 2000,
  parameter int unsigned T_EXEC_LONG = 82000,
  parameter int unsigned T_PWRUP     = 750000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_lcd_reg,
  input  logic        i_lcd_wr,
  input  logic [7:0]  i_lcd_dq,
  output logic [7:0]  o_lcd_dq,
  output logic        o_lcd_dq_oe,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_lcd_blon,
  output logic        o_busy,
  output logic [7:0]  o_rd_data,
  output logic        o_ovf
);

  localparam int unsigned T_MAX_A = (T_EXEC_LONG > T_EXEC) ? T_EXEC_LONG : T_EXEC;
  localparam int unsigned T_MAX_B = (T_PWRUP > T_MAX_A) ? T_PWRUP : T_MAX_A;
  localparam int unsigned T_MAX_C = (T_EN > T_MAX_B) ? T_EN : T_MAX_B;
  localparam int          CW      = (T_MAX_C > 1) ? $clog2(T_MAX_C) : 1;

  lcd_state_t    state, state_next;
  logic [CW-1:0] cnt, cnt_load;
  lcd_cmd_t      slot, active;
  logic          slot_full, slot_full_next, take;
  logic          lcd_on_q, bus_active;
  logic          init_pending;
  logic          unused_reg_bits;

  assign unused_reg_bits = ^i_lcd_reg[29:10];

`ifdef LCD_AUTO_INIT_EN
  logic [2:0] init_idx;
  assign init_pending = (init_idx < 3'(INIT_LEN));
`else
  assign init_pending = 1'b0;
`endif

  assign slot_full_next = i_lcd_wr | (slot_full & ~take);

  always_comb begin
    state_next = state;
    take       = 1'b0;
    cnt_load   = '0;
    case (state)
`ifdef LCD_AUTO_INIT_EN
      PWRUP: if (cnt == '0) state_next = INIT;
      INIT:  state_next = SETUP;
`endif
      IDLE: begin
        if (slot_full) begin
          take       = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: if (cnt == '0) state_next = PULSE;
      PULSE: if (cnt == '0) state_next = HOLD;
      HOLD:  if (cnt == '0) state_next = WAIT;
      WAIT:  if (cnt == '0) state_next = init_pending ? INIT : IDLE;
      default: state_next = IDLE;
    endcase
    case (state_next)
      SETUP:   cnt_load = CW'(T_SETUP - 1);
      PULSE:   cnt_load = CW'(T_EN - 1);
      HOLD:    cnt_load = CW'(T_HOLD - 1);
      WAIT:    cnt_load = is_long_cmd(active) ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
      default: cnt_load = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
`ifdef LCD_AUTO_INIT_EN
      state    <= PWRUP;
      cnt      <= CW'(T_PWRUP - 1);
      init_idx <= '0;
`else
      state    <= IDLE;
      cnt      <= '0;
`endif
      slot       <= '0;
      slot_full  <= 1'b0;
      active     <= '0;
      lcd_on_q   <= 1'b0;
      o_lcd_blon <= 1'b0;
      o_busy     <= 1'b0;
      o_rd_data  <= '0;
      o_ovf      <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= cnt_load;
      else if (cnt != '0)      cnt <= cnt - 1'b1;

      if (take) active <= slot;
`ifdef LCD_AUTO_INIT_EN
      if (state == INIT) begin
        active   <= init_cmd(init_idx[1:0]);
        init_idx <= init_idx + 1'b1;
      end
`endif
      // A command leaving the slot this cycle frees room, so a concurrent write is not an overflow.
      if (i_lcd_wr) begin
        slot.rs    <= i_lcd_reg[LCD_RS_BIT];
        slot.rw    <= i_lcd_reg[LCD_RW_BIT];
        slot.data  <= i_lcd_reg[7:0];
        lcd_on_q   <= i_lcd_reg[LCD_ON_BIT];
        o_lcd_blon <= i_lcd_reg[LCD_BLON_BIT];
        if (slot_full && !take) o_ovf <= 1'b1;
      end
      slot_full <= slot_full_next;

      if (state == PULSE && cnt == '0 && active.rw) o_rd_data <= i_lcd_dq;
      o_busy <= (state_next != IDLE) | slot_full_next;
    end
  end

  assign bus_active  = (state == SETUP) || (state == PULSE) || (state == HOLD);
  assign o_lcd_en    = (state == PULSE);
  assign o_lcd_rs    = bus_active & active.rs;
  assign o_lcd_rw    = bus_active & active.rw;
  assign o_lcd_dq_oe = bus_active & ~active.rw;
  assign o_lcd_dq    = bus_active ? active.data : 8'h00;
  assign o_lcd_on    = lcd_on_q | (init_pending & (state != PWRUP));

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer with short timing parameters; also covers LCD_AUTO_INIT_EN.
module tb_lcd_cmd_sequencer;

  localparam int unsigned P_SETUP = 2, P_EN = 4, P_HOLD = 1, P_EXEC = 10, P_LONG = 30, P_PWRUP = 20;
  localparam int NORM_LAT = 1 + P_SETUP + P_EN + P_HOLD + P_EXEC;  // 18
  localparam int LONG_LAT = 1 + P_SETUP + P_EN + P_HOLD + P_LONG;  // 38

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_lcd_reg;
  logic        i_lcd_wr;
  logic [7:0]  i_lcd_dq;
  logic [7:0]  o_lcd_dq;
  logic        o_lcd_dq_oe, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_lcd_blon, o_busy, o_ovf;
  logic [7:0]  o_rd_data;

  int nvec = 0;
  int errs = 0;
  int cyc  = 0;
  logic [7:0] bus_log[$];
  logic       prev_oe = 1'b0;

  lcd_cmd_sequencer #(
    .T_SETUP(P_SETUP), .T_EN(P_EN), .T_HOLD(P_HOLD),
    .T_EXEC(P_EXEC), .T_EXEC_LONG(P_LONG), .T_PWRUP(P_PWRUP)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_lcd_reg(i_lcd_reg), .i_lcd_wr(i_lcd_wr), .i_lcd_dq(i_lcd_dq),
    .o_lcd_dq(o_lcd_dq), .o_lcd_dq_oe(o_lcd_dq_oe), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
    .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on), .o_lcd_blon(o_lcd_blon), .o_busy(o_busy),
    .o_rd_data(o_rd_data), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1;
    if (o_lcd_dq_oe && !prev_oe) bus_log.push_back(o_lcd_dq);
    prev_oe = o_lcd_dq_oe;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] v);
    i_lcd_reg = v;
    i_lcd_wr  = 1'b1;
    tick();
    i_lcd_wr  = 1'b0;
  endtask

  task automatic wait_idle(input int start, output int delta);
    int n = 0;
    while (o_busy && n < 2000) begin
      tick();
      n++;
    end
    delta = cyc - start;
  endtask

  task automatic wait_init();
`ifdef LCD_AUTO_INIT_EN
    int d;
    tick();
    wait_idle(cyc, d);
`endif
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    repeat (3) tick();
    nvec++;
    if ({o_lcd_en, o_busy, o_lcd_on, o_lcd_blon, o_ovf} !== 5'b0) begin
      errs++; $display("FAIL reset_ctrl got %b want 00000", {o_lcd_en, o_busy, o_lcd_on, o_lcd_blon, o_ovf});
    end
    nvec++;
    if ({o_lcd_dq, o_lcd_dq_oe, o_lcd_rs, o_lcd_rw, o_rd_data} !== 19'b0) begin
      errs++; $display("FAIL reset_bus got dq=%h oe=%b rs=%b rw=%b rd=%h want zeros",
                       o_lcd_dq, o_lcd_dq_oe, o_lcd_rs, o_lcd_rw, o_rd_data);
    end
    i_rst = 1'b1;
`ifndef LCD_AUTO_INIT_EN
    repeat (2) tick();
    nvec++;
    if (o_busy !== 1'b0) begin errs++; $display("FAIL reset_idle busy=%b want 0", o_busy); end
`endif
  endtask

  task automatic test_auto_init();
`ifdef LCD_AUTO_INIT_EN
    int   start, n;
    logic busy_drop = 1'b0, on_seen = 1'b0;
    bus_log.delete();
    start = cyc;
    tick();
    n = 0;
    while (n < 2000 && (o_busy || n == 0)) begin
      if (o_lcd_en && o_lcd_on) on_seen = 1'b1;
      tick();
      n++;
      if (!o_busy && bus_log.size() < 4) busy_drop = 1'b1;
    end
    nvec++;
    if (bus_log.size() !== 4) begin errs++; $display("FAIL init_count got %0d want 4", bus_log.size()); end
    else begin
      nvec++;
      if ({bus_log[0], bus_log[1], bus_log[2], bus_log[3]} !== 32'h380C0106) begin
        errs++; $display("FAIL init_seq got %h %h %h %h want 38 0c 01 06",
                         bus_log[0], bus_log[1], bus_log[2], bus_log[3]);
      end
    end
    nvec++;
    if (busy_drop) begin errs++; $display("FAIL init_busy busy dropped before last command"); end
    nvec++;
    if (cyc - start !== P_PWRUP + 4 * (2 + P_SETUP + P_EN + P_HOLD) - 4 + 3 * P_EXEC + P_LONG) begin
      errs++; $display("FAIL init_len got %0d want %0d", cyc - start,
                       P_PWRUP + 4 * (2 + P_SETUP + P_EN + P_HOLD) - 4 + 3 * P_EXEC + P_LONG);
    end
    nvec++;
    if (!on_seen) begin errs++; $display("FAIL init_on lcd_on not forced during init"); end
`endif
  endtask

  task automatic test_write_data();
    int s, n, d;
    wr(32'h8000_0241);
    s = cyc;
    nvec++;
    if ({o_busy, o_lcd_on, o_lcd_en, o_lcd_dq_oe} !== 4'b1100) begin
      errs++; $display("FAIL wr_capture busy/on/en/oe got %b want 1100", {o_busy, o_lcd_on, o_lcd_en, o_lcd_dq_oe});
    end
    tick();
    nvec++;
    if ({o_lcd_rs, o_lcd_rw, o_lcd_dq, o_lcd_dq_oe, o_lcd_en} !== {2'b10, 8'h41, 2'b10}) begin
      errs++; $display("FAIL wr_setup rs=%b rw=%b dq=%h oe=%b en=%b want 1 0 41 1 0",
                       o_lcd_rs, o_lcd_rw, o_lcd_dq, o_lcd_dq_oe, o_lcd_en);
    end
    tick();
    nvec++;
    if (o_lcd_en !== 1'b0) begin errs++; $display("FAIL wr_setup2 en=%b want 0", o_lcd_en); end
    tick();
    n = 0;
    while (o_lcd_en && n < 100) begin tick(); n++; end
    nvec++;
    if (n !== P_EN) begin errs++; $display("FAIL wr_en_width got %0d want %0d", n, P_EN); end
    nvec++;
    if ({o_lcd_dq, o_lcd_dq_oe, o_lcd_rs} !== {8'h41, 2'b11}) begin
      errs++; $display("FAIL wr_hold dq=%h oe=%b rs=%b want 41 1 1", o_lcd_dq, o_lcd_dq_oe, o_lcd_rs);
    end
    tick();
    nvec++;
    if (o_lcd_dq_oe !== 1'b0) begin errs++; $display("FAIL wr_wait_oe oe=%b want 0", o_lcd_dq_oe); end
    wait_idle(s, d);
    nvec++;
    if (d !== NORM_LAT) begin errs++; $display("FAIL wr_busy_len got %0d want %0d", d, NORM_LAT); end
  endtask

  task automatic test_exec_time();
    logic [31:0] regs[4] = '{32'h0000_0001, 32'h0000_0003, 32'h0000_0004, 32'h0000_0201};
    int          lat[4]  = '{LONG_LAT, LONG_LAT, NORM_LAT, NORM_LAT};
    int s, d;
    for (int i = 0; i < 4; i++) begin
      wr(regs[i]);
      s = cyc;
      wait_idle(s, d);
      nvec++;
      if (d !== lat[i]) begin errs++; $display("FAIL exec_time reg=%h got %0d want %0d", regs[i], d, lat[i]); end
    end
  endtask

  task automatic test_read();
    int   s, d, n, oe_bad;
    logic rw_seen;
    logic [7:0] rd_before, rd_at_fall;
    i_lcd_dq = 8'h11; oe_bad = 0; rw_seen = 1'b0; n = 0; rd_before = 8'hxx; rd_at_fall = 8'hxx;
    wr(32'h0000_0100);
    s = cyc;
    for (int k = 0; k < 200 && o_busy; k++) begin
      if (o_lcd_dq_oe) oe_bad++;
      if (o_lcd_rw) rw_seen = 1'b1;
      if (o_lcd_en) begin
        n++;
        if (n == P_EN) begin rd_before = o_rd_data; i_lcd_dq = 8'h5A; end
      end else if (n == P_EN) begin
        rd_at_fall = o_rd_data;
        n++;
      end
      tick();
    end
    wait_idle(s, d);
    i_lcd_dq = 8'hFF;
    tick();
    nvec++;
    if (rd_before !== 8'h00) begin errs++; $display("FAIL rd_early got %h want 00", rd_before); end
    nvec++;
    if (rd_at_fall !== 8'h5A) begin errs++; $display("FAIL rd_fall got %h want 5a", rd_at_fall); end
    nvec++;
    if (oe_bad !== 0) begin errs++; $display("FAIL rd_oe got %0d oe cycles want 0", oe_bad); end
    nvec++;
    if (rw_seen !== 1'b1) begin errs++; $display("FAIL rd_rw got %b want 1", rw_seen); end
    nvec++;
    if (o_rd_data !== 8'h5A) begin errs++; $display("FAIL rd_keep got %h want 5a", o_rd_data); end
  endtask

  task automatic test_back_to_back();
    int s, d;
    logic [7:0] v0, v1;
    nvec++;
    if (o_ovf !== 1'b0) begin errs++; $display("FAIL b2b_ovf_pre got %b want 0", o_ovf); end
    bus_log.delete();
    i_lcd_wr = 1'b1;
    i_lcd_reg = 32'h0000_0241; tick();
    i_lcd_reg = 32'h0000_0242; tick();
    i_lcd_reg = 32'h0000_0243; tick();
    i_lcd_wr = 1'b0;
    s = cyc;
    wait_idle(s, d);
    v0 = (bus_log.size() > 0) ? bus_log[0] : 8'h00;
    v1 = (bus_log.size() > 1) ? bus_log[1] : 8'h00;
    nvec++;
    if (bus_log.size() !== 2) begin errs++; $display("FAIL b2b_count got %0d want 2", bus_log.size()); end
    nvec++;
    if ({v0, v1} !== 16'h4143) begin errs++; $display("FAIL b2b_order got %h %h want 41 43", v0, v1); end
    nvec++;
    if (o_ovf !== 1'b1) begin errs++; $display("FAIL b2b_ovf got %b want 1", o_ovf); end
  endtask

  task automatic test_reset_mid();
    int s, d, n;
    wr(32'hC000_0241);
    n = 0;
    while (!o_lcd_en && n < 50) begin tick(); n++; end
    tick();
    nvec++;
    if (o_lcd_en !== 1'b1) begin errs++; $display("FAIL rst_mid_pulse en=%b want 1", o_lcd_en); end
    i_rst = 1'b0;
    tick();
    nvec++;
    if ({o_lcd_en, o_busy, o_lcd_on, o_lcd_blon, o_ovf, o_lcd_dq_oe, o_lcd_rs} !== 7'b0) begin
      errs++; $display("FAIL rst_mid_ctrl got %b want 0000000",
                       {o_lcd_en, o_busy, o_lcd_on, o_lcd_blon, o_ovf, o_lcd_dq_oe, o_lcd_rs});
    end
    nvec++;
    if ({o_lcd_dq, o_rd_data} !== 16'h0) begin
      errs++; $display("FAIL rst_mid_data dq=%h rd=%h want 00 00", o_lcd_dq, o_rd_data);
    end
    i_rst = 1'b1;
    wait_init();
    wr(32'h0000_0242);
    s = cyc;
    tick();
    nvec++;
    if ({o_lcd_dq, o_lcd_dq_oe} !== {8'h42, 1'b1}) begin
      errs++; $display("FAIL rst_mid_after dq=%h oe=%b want 42 1", o_lcd_dq, o_lcd_dq_oe);
    end
    wait_idle(s, d);
    nvec++;
    if (d !== NORM_LAT) begin errs++; $display("FAIL rst_mid_len got %0d want %0d", d, NORM_LAT); end
  endtask

  initial begin
    i_rst = 1'b0; i_lcd_wr = 1'b0; i_lcd_reg = '0; i_lcd_dq = '0;
    test_reset();
    test_auto_init();
    test_write_data();
    test_exec_time();
    test_read();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
